// File: rtl/yuv_block_sequencer.sv
// yuv_block_sequencer
// Captures one MCU (Y, U, V 8x8 coefficient blocks) from the DCT stage and
// sends the blocks downstream one at a time in Y, U, V order over a
// valid/ready handshake. Tracks the MCU index and flags end of frame.
module yuv_block_sequencer #(
    parameter int MCU_SIZE      = 8,
    parameter int COEF_BITWIDTH = 12,
    parameter int MCU_CNT_WIDTH = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   i_dct_valid,
    input  logic                                                   i_dct_last,
    input  logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][COEF_BITWIDTH-1:0] i_y,
    input  logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][COEF_BITWIDTH-1:0] i_u,
    input  logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][COEF_BITWIDTH-1:0] i_v,
    output logic                                                   o_dct_wait,
    output logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][COEF_BITWIDTH-1:0] o_blk,
    output logic [1:0]                                             o_comp,
    output logic                                                   o_blk_valid,
    input  logic                                                   i_blk_ready,
    output logic                                                   o_blk_last,
    output logic [MCU_CNT_WIDTH-1:0]                               o_mcu_idx,
    output logic                                                   o_frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_Y = 2'd1,
        SEND_U = 2'd2,
        SEND_V = 2'd3
    } state_t;

    state_t                                                  state_r;
    state_t                                                  state_next_s;
    logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][COEF_BITWIDTH-1:0] y_r;
    logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][COEF_BITWIDTH-1:0] u_r;
    logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][COEF_BITWIDTH-1:0] v_r;
    logic                                                    last_r;
    logic [MCU_CNT_WIDTH-1:0]                                mcu_idx_r;
    logic                                                    frame_done_r;
    logic                                                    acc_s;
    logic                                                    xfer_s;
    logic                                                    v_xfer_s;

    // Handshake decode from state; wait drops in SEND_V when the V block is
    // being taken so the next MCU can be captured without a bubble.
    always_comb begin
        o_dct_wait  = 1'b1;
        o_blk_valid = 1'b0;
        o_blk_last  = 1'b0;
        if (state_r == IDLE) begin
            o_dct_wait = 1'b0;
        end else begin
            o_blk_valid = 1'b1;
            if (state_r == SEND_V) begin
                o_dct_wait = ~i_blk_ready;
                o_blk_last = last_r;
            end else begin
                o_dct_wait = 1'b1;
            end
        end
    end

    assign acc_s    = i_dct_valid & ~o_dct_wait;
    assign xfer_s   = o_blk_valid & i_blk_ready;
    assign v_xfer_s = xfer_s & (state_r == SEND_V);

    // Next-state logic: advance only on a downstream transfer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    state_next_s = SEND_Y;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND_Y: begin
                if (xfer_s) begin
                    state_next_s = SEND_U;
                end else begin
                    state_next_s = SEND_Y;
                end
            end
            SEND_U: begin
                if (xfer_s) begin
                    state_next_s = SEND_V;
                end else begin
                    state_next_s = SEND_U;
                end
            end
            SEND_V: begin
                if (xfer_s) begin
                    state_next_s = acc_s ? SEND_Y : IDLE;
                end else begin
                    state_next_s = SEND_V;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output block/component mux; held stable by the stored registers.
    always_comb begin
        o_blk  = y_r;
        o_comp = 2'd0;
        case (state_r)
            SEND_Y: begin
                o_blk  = y_r;
                o_comp = 2'd0;
            end
            SEND_U: begin
                o_blk  = u_r;
                o_comp = 2'd1;
            end
            SEND_V: begin
                o_blk  = v_r;
                o_comp = 2'd2;
            end
            default: begin
                o_blk  = y_r;
                o_comp = 2'd0;
            end
        endcase
    end

    // Coefficient storage; not reset since it is only observed while valid.
    always_ff @(posedge clk) begin
        if (acc_s) begin
            y_r <= i_y;
            u_r <= i_u;
            v_r <= i_v;
        end else begin
            y_r <= y_r;
            u_r <= u_r;
            v_r <= v_r;
        end
    end

    // Control state, last flag, MCU counter and frame-done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_r       <= 1'b0;
            mcu_idx_r    <= {MCU_CNT_WIDTH{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            frame_done_r <= v_xfer_s & last_r;
            if (acc_s) begin
                last_r <= i_dct_last;
            end else begin
                last_r <= last_r;
            end
            if (v_xfer_s) begin
                if (last_r) begin
                    mcu_idx_r <= {MCU_CNT_WIDTH{1'b0}};
                end else begin
                    mcu_idx_r <= mcu_idx_r + {{(MCU_CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                mcu_idx_r <= mcu_idx_r;
            end
        end
    end

    assign o_mcu_idx    = mcu_idx_r;
    assign o_frame_done = frame_done_r;

endmodule
